// File: rtl/int_to_float32_pipe.sv
// Three-stage integer to IEEE-754 single-precision converter with
// round-to-nearest-even, an inexact flag and a valid/ready stream interface.
module int_to_float32_pipe #(
    parameter int IN_WIDTH = 32,
    parameter bit SIGNED   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_x,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic [IN_WIDTH-1:0] i_in,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [31:0]         o_out,
    output logic                o_inexact
);

    localparam int IDX_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int EXT_W = IN_WIDTH + 25;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(IN_WIDTH - 1);

    // Returns {inexact, sign, exponent, fraction}. The normalised magnitude is
    // padded below so narrow inputs yield guard/sticky of zero naturally.
    function automatic logic [32:0] round_pack(
        input logic                sign,
        input logic [7:0]          exp,
        input logic [IN_WIDTH-1:0] norm,
        input logic                zero
    );
        logic [EXT_W-1:0] ext;
        logic [22:0]      frac;
        logic             guard;
        logic             sticky;
        logic             rnd_up;
        logic [23:0]      frac_r;
        logic [7:0]       exp_r;
        ext    = {norm, 25'b0};
        frac   = ext[IN_WIDTH+23 -: 23];
        guard  = ext[IN_WIDTH];
        sticky = |ext[IN_WIDTH-1:0];
        rnd_up = guard & (sticky | frac[0]);
        frac_r = {1'b0, frac} + {23'b0, rnd_up};
        exp_r  = exp + {7'b0, frac_r[23]};
        if (zero) begin
            round_pack = '0;
        end else begin
            round_pack = {guard | sticky, sign, exp_r, frac_r[22:0]};
        end
    endfunction

    logic                       en;
    logic signed [IN_WIDTH-1:0] in_s;
    logic                       sign_c;
    logic [IN_WIDTH-1:0]        mag_c;

    logic                       vld_p0;
    logic                       sign_p0;
    logic [IN_WIDTH-1:0]        mag_p0;

    logic [IDX_W-1:0]           lead_idx;
    logic [IN_WIDTH-1:0]        norm_c;
    logic [7:0]                 exp_c;
    logic                       zero_c;

    logic                       vld_p1;
    logic                       sign_p1;
    logic [IN_WIDTH-1:0]        norm_p1;
    logic [7:0]                 exp_p1;
    logic                       zero_p1;

    logic                       vld_p2;
    logic [31:0]                out_p2;
    logic                       inexact_p2;

    assign en      = ~vld_p2 | o_ready;
    assign i_ready = en;

    // Stage 1 input: sign and magnitude
    assign in_s   = $signed(i_in);
    assign sign_c = SIGNED & i_in[IN_WIDTH-1];
    assign mag_c  = sign_c ? $unsigned(-in_s) : i_in;

    // Stage 2 input: leading-one search and normalisation
    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (mag_p0[i]) lead_idx = IDX_W'(i);
        end
    end

    assign zero_c = (mag_p0 == '0);
    assign norm_c = mag_p0 << (TOP_IDX - lead_idx);
    assign exp_c  = 8'd127 + 8'(lead_idx);

    // Valid bits and output registers are reset; they drop asynchronously.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            out_p2     <= '0;
            inexact_p2 <= 1'b0;
        end else if (en) begin
            vld_p0                 <= i_valid;
            vld_p1                 <= vld_p0;
            vld_p2                 <= vld_p1;
            {inexact_p2, out_p2}   <= round_pack(sign_p1, exp_p1, norm_p1, zero_p1);
        end
    end

    // Internal datapath registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (en) begin
            sign_p0 <= sign_c;
            mag_p0  <= mag_c;
            sign_p1 <= sign_p0;
            norm_p1 <= norm_c;
            exp_p1  <= exp_c;
            zero_p1 <= zero_c;
        end
    end

    assign o_valid   = vld_p2;
    assign o_out     = out_p2;
    assign o_inexact = inexact_p2;

endmodule

// File: doc/int_to_float32_pipe.md
Name: int_to_float32_pipe

Overview:
- Parametrised, pipelined integer-to-IEEE-754 single-precision converter.
- It is the hardware successor to the PLI float32 conversion used by the scenario benches, so mod_top-class datapaths can produce float32 in RTL.
- Supports configurable input width and signed or unsigned interpretation, with round-to-nearest-even and an inexact flag.
- Uses a valid/ready streaming handshake with full backpressure.

Parameters:
- IN_WIDTH, 32, integer input width in bits; legal range 2..64.
- SIGNED, 1, 1 = two's-complement input, 0 = unsigned input.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_x  in  1  asynchronous active-low reset.
- i_valid  in  1  input word present.
- i_ready  out  1  converter can accept a word this cycle.
- i_in  in  IN_WIDTH  integer to convert.
- o_valid  out  1  result present.
- o_ready  in  1  downstream accepts the result.
- o_out  out  32  float32 result: sign[31], exponent[30:23], fraction[22:0].
- o_inexact  out  1  result was rounded, i.e. not exactly equal to the input.

Behaviour:
- Reset (async assert, sync-released use): o_valid=0, o_out=0, o_inexact=0, all stage valid bits=0, i_ready=1 once out of reset.
  - Asserting reset mid-operation discards all in-flight words.
- Pipeline structure: 3 register stages, S1 -> S2 -> S3; S3 drives the outputs.
  - Global advance enable: en = ~o_valid | o_ready; i_ready = en.
  - Transfer in when i_valid & i_ready; transfer out when o_valid & o_ready.
  - When en=0, every stage holds, including data and valid bits.
  - Bubbles propagate as valid=0 stages and are not compressed.
- Latency: 3 cycles from the accepting edge to o_valid, given no stall. Throughput is 1 word/cycle.
- S1 (sign/magnitude):
  - sign = SIGNED & i_in[IN_WIDTH-1]; otherwise 0.
  - mag = sign ? -i_in : i_in, held as IN_WIDTH-bit unsigned.
  - The most-negative signed value gives mag = 2^(IN_WIDTH-1), which is representable; there is no special case.
- S2 (normalise):
  - zero = (mag==0).
  - p = index of the leading one, found by a priority encoder.
  - Left-shift mag so the leading one sits at bit IN_WIDTH-1.
  - exp = 127 + p, 8 bits; no overflow is possible for IN_WIDTH<=64.
- S3 (round and pack):
  - If p <= 23, the fraction is exact: fraction = bits below the leading one, zero-padded; inexact = 0.
  - Otherwise keep 23 fraction bits; guard = next bit; sticky = OR of all remaining bits.
  - Round up when guard & (sticky | fraction LSB).
  - inexact = guard | sticky.
  - If round-up carries out of the fraction: fraction=0, exp=exp+1.
- Zero input: o_out = 0x00000000, o_inexact = 0. Negative zero is never produced.
- Output encoding: only normal numbers and +0 are produced; no NaN, Inf or denormal.
- Simultaneous accept and emit with o_ready=1 and a full pipe is legal; one word enters and one leaves in the same cycle.
- o_out and o_inexact must be stable while o_valid=1 and o_ready=0.
- Ordering: results leave strictly in input order.

Test Plan:
- Reset, then stream i_in = 0..9 back-to-back with o_ready=1.
  - o_valid rises exactly 3 cycles after the first accept.
  - Outputs: 0x00000000, 0x3F800000, 0x40000000, 0x40400000, 0x40800000, 0x40A00000, 0x40C00000, 0x40E00000, 0x41000000, 0x41100000.
  - o_inexact = 0 throughout.
- SIGNED=1, inputs -1, 0x80000000, 0x7FFFFFFF:
  - 0xBF800000, inexact=0.
  - 0xCF000000, inexact=0.
  - 0x4F000000, inexact=1 (rounds up to 2^31).
- Rounding ties, inputs 16777217 and 16777219:
  - 0x4B800000, inexact=1 (tie rounds to even, i.e. down).
  - 0x4B800002, inexact=1 (tie rounds to even, i.e. up).
- SIGNED=0, IN_WIDTH=32, input 0xFFFFFFFF:
  - 0x4F800000, inexact=1; exponent increments on the carry.
- Backpressure: stream 8 words while o_ready follows the pattern 1,0,0,1,0,1,1,0...
  - No loss and no duplication; order preserved.
  - o_out is held constant while stalled.
  - i_ready equals ~o_valid | o_ready every cycle.
- Reset asserted asynchronously with 3 words in flight:
  - o_valid drops immediately, with no clock edge needed.
  - After release, the first new word appears 3 cycles after its accept.
  - No stale word is ever emitted.
